// File: rtl/segasys1_sndcmd_fifo.sv
// segasys1_sndcmd_fifo
// Command mailbox from the main CPU to the sound CPU. Each main-CPU write
// access is edge-detected and queued in a first-word-fall-through FIFO. The
// sound CPU is interrupted while the queue holds entries, and each of its
// read accesses pops one entry.
//
// Ports
//   CLK40M  : system clock, rising edge
//   RESET   : synchronous active-high reset
//   HWR/HDI : main-CPU write strobe (level) and write data
//   SRD     : sound-CPU read strobe (level); the pop happens on its falling edge
//   SDO     : head entry, all ones when empty
//   SRQ     : sound interrupt request (queue not empty)
//   SPULSE  : one-clock pulse per accepted push (legacy request)
//   EMPTY/FULL/CNT : occupancy status
//   OVF/OVFCLR     : sticky overflow flag and its level clear
module segasys1_sndcmd_fifo #(
    parameter int DW        = 8,
    parameter int DEPTH     = 4,
    parameter int OVERWRITE = 0
) (
    input  logic                     CLK40M,
    input  logic                     RESET,
    input  logic                     HWR,
    input  logic [DW-1:0]            HDI,
    input  logic                     SRD,
    output logic [DW-1:0]            SDO,
    output logic                     SRQ,
    output logic                     SPULSE,
    output logic                     EMPTY,
    output logic                     FULL,
    output logic [$clog2(DEPTH):0]   CNT,
    output logic                     OVF,
    input  logic                     OVFCLR
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic OVW_EN = (OVERWRITE != 0);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wp;
    logic [AW-1:0] rp;
    logic [CW-1:0] cnt;
    logic          hwr_q;
    logic          srd_q;
    logic          spulse_q;
    logic          ovf_q;

    logic push_req;
    logic pop_req;
    logic empty;
    logic full;
    logic do_pop;
    logic do_push;
    logic do_ovw;
    logic ovf_set;

    assign push_req = HWR & ~hwr_q;
    // Falling edge so SDO stays stable for the whole read access.
    assign pop_req  = ~SRD & srd_q;

    assign empty    = (cnt == '0);
    assign full     = (cnt == CW'(DEPTH));

    assign do_pop   = pop_req & ~empty;
    // A pop in the same clock frees the slot a full queue would otherwise lack.
    assign do_push  = push_req & (~full | do_pop);
    assign ovf_set  = push_req & full & ~do_pop;
    assign do_ovw   = ovf_set & OVW_EN;

    always_ff @(posedge CLK40M) begin
        if (RESET) begin
            wp       <= '0;
            rp       <= '0;
            cnt      <= '0;
            hwr_q    <= 1'b0;
            srd_q    <= 1'b0;
            spulse_q <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            hwr_q    <= HWR;
            srd_q    <= SRD;
            spulse_q <= do_push | do_ovw;

            if (do_push) begin
                wp <= wp + AW'(1);
            end
            if (do_pop) begin
                rp <= rp + AW'(1);
            end

            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase

            // Set has priority over a simultaneous clear.
            if (ovf_set) begin
                ovf_q <= 1'b1;
            end else if (OVFCLR) begin
                ovf_q <= 1'b0;
            end
        end
    end

    // Storage is not reset; writes are still suppressed while RESET is high.
    always_ff @(posedge CLK40M) begin
        if (!RESET) begin
            if (do_push) begin
                mem[wp] <= HDI;
            end else if (do_ovw) begin
                mem[wp - AW'(1)] <= HDI;
            end
        end
    end

    assign SDO    = empty ? {DW{1'b1}} : mem[rp];
    assign SRQ    = ~empty;
    assign SPULSE = spulse_q;
    assign EMPTY  = empty;
    assign FULL   = full;
    assign CNT    = cnt;
    assign OVF    = ovf_q;

endmodule

// File: doc/segasys1_sndcmd_fifo.md
# segasys1_sndcmd_fifo

Parametrised main-to-sound command mailbox that supersedes the single-entry sound request latch on the main CPU's I/O write port. Main-CPU writes are edge-detected and queued in a DEPTH-entry first-word-fall-through FIFO. The sound CPU is interrupted while the queue is non-empty and pops one entry per read access. Full/overflow policy is selectable, and a legacy one-cycle request pulse is kept for existing sound-side logic.

## Interface
- DW, 8, command width in bits
- DEPTH, 4, FIFO entries; power of two, 2..16
- OVERWRITE, 0, full-FIFO policy: 0 = drop the incoming command, 1 = replace the newest queued entry
- CLK40M  in  1  system clock; all logic on its rising edge
- RESET  in  1  synchronous, active-high reset
- HWR  in  1  main-CPU write strobe (I/O write decode & wr); level, may stay high for many clocks
- HDI  in  DW  main-CPU write data, sampled on the push cycle
- SRD  in  1  sound-CPU read strobe for the command port; level
- SDO  out  DW  head entry (FWFT); all ones when EMPTY
- SRQ  out  1  sound interrupt request, equal to ~EMPTY
- SPULSE  out  1  one-clock pulse per accepted push (legacy SNDRQ)
- EMPTY  out  1  queue holds 0 entries
- FULL  out  1  queue holds DEPTH entries
- CNT  out  $clog2(DEPTH)+1  current occupancy
- OVF  out  1  sticky overflow flag
- OVFCLR  in  1  clears OVF (level)

## Operation
- Edge detectors: hwr_q <= HWR and srd_q <= SRD every clock.
  - push_req = HWR & ~hwr_q, so exactly one push per write access.
  - pop_req = ~SRD & srd_q, the falling edge, so SDO holds stable for the whole read access.
- Storage: DEPTH x DW register array, write pointer wp and read pointer rp, each log2(DEPTH) bits and wrapping modulo DEPTH.
  - cnt holds 0..DEPTH.
  - EMPTY = (cnt==0), FULL = (cnt==DEPTH), CNT = cnt.
- pop_req when not EMPTY: rp++, cnt--. pop_req when EMPTY is ignored and does not change OVF.
- push_req when not FULL: mem[wp] <= HDI, wp++, cnt++, SPULSE=1 on the next clock.
- push_req when FULL with a simultaneous valid pop:
  - Both are performed and cnt is unchanged.
  - This is not an overflow; SPULSE=1.
- push_req when FULL without a pop:
  - OVERWRITE=0: data is discarded, OVF <= 1, SPULSE stays 0.
  - OVERWRITE=1: mem[wp-1] <= HDI, pointers and cnt are unchanged, OVF <= 1, SPULSE=1.
- push_req and pop_req together when EMPTY: the push is performed and the pop is ignored, so cnt becomes 1.
- OVF: set as above; OVFCLR=1 clears it. If set and clear occur on the same clock, set wins.
- SDO = EMPTY ? {DW{1'b1}} : mem[rp], decoded combinationally from registers.

## Timing
- Reset (clock edge with RESET=1) forces: wp=rp=0, cnt=0, OVF=0, hwr_q=srd_q=0, SPULSE=0.
  - Outputs after that edge: EMPTY=1, FULL=0, SRQ=0, CNT=0, SDO=all ones.
  - Array contents are not reset.
- Reset overrides every other event. A HWR held high across reset release produces a push on the first clock after release, because hwr_q resets to 0.
- Push latency: with HWR rising before edge N, cnt, EMPTY, SRQ and SDO update after edge N, and SPULSE is high for exactly the cycle after edge N.
- Pop latency: with SRD falling before edge N, the next entry appears on SDO after edge N.
- Maximum throughput is one push and one pop per clock.
- The block has no clock enable; strobes gated by the CPU clock enable arrive as multi-clock levels and are edge-detected.

## Test plan
- Reset, then HWR high for 8 clocks with HDI=8'h5A:
  - Exactly one push.
  - CNT=1, SRQ=1, SDO=8'h5A.
  - SPULSE high for exactly one cycle.
- DEPTH=4: push 01,02,03,04, then five SRD read accesses:
  - SDO sequence 01,02,03,04 with FULL asserted after the fourth push.
  - The fifth read leaves CNT=0 and SDO=8'hFF.
  - OVF stays 0.
- DEPTH=4, OVERWRITE=0: push 01..04, then push 05:
  - CNT=4, OVF=1, no SPULSE.
  - Drain yields 01,02,03,04.
  - Then OVFCLR for 1 clock, after which OVF=0.
- DEPTH=4, OVERWRITE=1: push 01..04, then push 05:
  - CNT=4, OVF=1, SPULSE pulses.
  - Drain yields 01,02,03,05.
- FULL plus simultaneous HWR rise (HDI=0x77) and SRD fall:
  - CNT stays 4, OVF=0.
  - Drain yields the three older entries, then 0x77.
  - The pointer wrap past DEPTH-1 is exercised.
- EMPTY plus simultaneous push of 0x33 and pop; then RESET asserted mid-queue with CNT=3:
  - First case: CNT=1, SDO=0x33.
  - After reset: CNT=0, EMPTY=1, OVF=0, SDO=8'hFF.
